pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
Parametrised, pipelined successor to the single-bit half adder. Adds two WIDTH-bit unsigned operands plus a carry-in. The carry chain is split into STAGES equal chunks, with one register stage per chunk. Valid/ready handshakes on both sides let it sit in streaming datapaths with backpressure.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages; chunk width CW = WIDTH/STAGES; STAGES >= 1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  operands a/b/cin valid this cycle.
in_ready  output  1  block accepts operands this cycle.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
cin  input  1  carry-in into bit 0.
out_valid  output  1  sum/cout valid.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  result bits, (a+b+cin) mod 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Interface decision: one clock (clk); reset rst_n is synchronous and active-low. It is sampled only on the rising clk edge.
- Reset state:
  - All stage valid bits are 0, so out_valid=0.
  - All stage data and carry registers are 0, so sum=0 and cout=0.
  - in_ready=1 in the first cycle after reset.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv, driven combinationally.
  - There are no other combinational paths from inputs to outputs.
- Accept rule: an operand is accepted when in_valid && in_ready.
  - Stage 0's valid bit loads (in_valid && in_ready) whenever adv=1.
- Stage k (0..STAGES-1), when adv=1:
  - Adds chunk k of a and b (bits k*CW..k*CW+CW-1) plus the carry registered by stage k-1 (cin for k=0).
  - Registers the CW-bit chunk sum and the chunk carry.
  - Forwards the already-computed lower sum chunks.
  - Forwards the not-yet-added upper a/b chunks.
  - Shifts its valid bit to stage k+1.
- Hold on stall: when adv=0, every stage register holds. sum, cout and out_valid stay stable until taken.
- Latency: a result appears STAGES cycles after acceptance when unstalled. Throughput is 1 operation per cycle.
- Bubbles: the pipeline is lock-step, so bubbles are not compressed. An empty slot still travels the full depth.
- Ordering: results leave strictly in acceptance order. No result is lost or duplicated under any out_ready pattern.
- Final stage output:
  - sum = concatenation of all chunk sums.
  - cout = carry out of the top chunk.
- STAGES=1 degenerates to a single registered full-width adder with latency 1.
- Reset mid-operation: all in-flight operations are discarded. No result from before reset ever asserts out_valid afterwards.
- Simultaneous output take and input accept in the same cycle is legal and required for full throughput.

Optional Feature:
ADDER_SATURATE_EN:
- Defined: unsigned saturation at the output stage. If the final carry=1, sum is forced to all ones. cout still reports 1 as the overflow flag. Latency is unchanged.
- Undefined: sum wraps modulo 2^WIDTH; cout is the raw carry.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=0x1234 -> out_valid=0, sum=0x0000, cout=0, in_ready=1; nothing emerges afterwards.
2. Chunk-boundary carry (WIDTH=16, STAGES=4): a=0x00FF, b=0x0001, cin=0 -> exactly 4 cycles later out_valid=1, sum=0x0100, cout=0. Also a=0, b=0, cin=1 -> sum=0x0001.
3. Full ripple/overflow: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. With ADDER_SATURATE_EN defined -> sum=0xFFFF, cout=1.
4. Streaming: 8 back-to-back ops a=i*0x1111, b=0x0F0F, out_ready=1 -> 8 results on consecutive cycles starting 4 cycles after the first accept, in order, each matching a reference model.
5. Backpressure: deassert out_ready for 3 cycles while out_valid=1 -> sum/cout held constant and in_ready=0. After out_ready returns, all queued results arrive in order with none lost or duplicated.
6. Reset mid-flight: accept 2 ops, then pulse rst_n=0 for 1 cycle before either emerges -> out_valid stays 0 for the following 6 cycles.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit unsigned adder (a + b + cin). The carry chain is
// split into STAGES chunks of CW = WIDTH/STAGES bits, with one register stage
// per chunk. WIDTH must be a multiple of STAGES, and STAGES >= 1.
//
// Optional feature, selected by the macro ADDER_SATURATE_EN:
//   defined   - unsigned saturation: when the final carry is 1, sum is forced
//               to all ones; cout still reports 1 as the overflow flag.
//   undefined - sum wraps modulo 2^WIDTH; cout is the raw carry.
//
// Handshake: a transfer happens on a rising clk edge when valid && ready are
// both high on that side. Valid does not depend on ready. The pipeline moves
// in lock-step: it advances when the output register is empty or is being
// taken (adv = !out_valid || out_ready), and in_ready equals adv. When adv is
// low, every stage holds, so sum, cout and out_valid stay stable until taken.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = WIDTH / STAGES;

    // Per-stage registers. Each stage keeps full-width a/b/sum vectors:
    // chunks below the stage index hold finished sum bits, and chunks above it
    // hold operand bits that have not been added yet.
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_carry;
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];

    // Values presented to each stage and the values it computes.
    logic [WIDTH-1:0]  w_a_in   [STAGES];
    logic [WIDTH-1:0]  w_b_in   [STAGES];
    logic [WIDTH-1:0]  w_s_in   [STAGES];
    logic [WIDTH-1:0]  w_s_next [STAGES];
    logic [STAGES-1:0] w_c_in;
    logic [CW:0]       w_chunk  [STAGES];
    logic              w_adv;

    assign w_adv     = !out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_valid[STAGES-1];
    assign cout      = r_carry[STAGES-1];

`ifdef ADDER_SATURATE_EN
    assign sum = r_carry[STAGES-1] ? {WIDTH{1'b1}} : r_sum[STAGES-1];
`else
    assign sum = r_sum[STAGES-1];
`endif

    // Route stage inputs and add one CW-bit chunk per stage.
    always_comb begin
        w_a_in[0] = a;
        w_b_in[0] = b;
        w_s_in[0] = '0;
        w_c_in[0] = cin;
        for (int k = 1; k < STAGES; k++) begin
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_s_in[k] = r_sum[k-1];
            w_c_in[k] = r_carry[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_chunk[k] = {1'b0, w_a_in[k][k*CW +: CW]}
                       + {1'b0, w_b_in[k][k*CW +: CW]}
                       + {{CW{1'b0}}, w_c_in[k]};
            w_s_next[k] = w_s_in[k];
            w_s_next[k][k*CW +: CW] = w_chunk[k][CW-1:0];
        end
    end

    // Stage registers: clear on reset, shift in lock-step when adv, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_carry <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
            end
        end else if (w_adv) begin
            // in_ready equals adv here, so this is in_valid && in_ready.
            r_valid[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]     <= w_a_in[k];
                r_b[k]     <= w_b_in[k];
                r_sum[k]   <= w_s_next[k];
                r_carry[k] <= w_chunk[k][CW];
            end
        end
    end

endmodule
